// File: rtl/lru_set_tracker_if.sv
// Update/query bundle for lru_set_tracker: the requester drives updates and queries, the tracker returns victims.
interface lru_set_tracker_if #(
    parameter int WAYS = 4,
    parameter int SETS = 16
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic             upd_valid;
    logic [SET_W-1:0] upd_set;
    logic [WAYS-1:0]  upd_way;
    logic             upd_inv;
    logic             q_valid;
    logic [SET_W-1:0] q_set;
    logic             victim_valid;
    logic [WAYS-1:0]  victim_oh;
    logic [WAY_W-1:0] victim_idx;
    logic             upd_err;

    modport master (
        output upd_valid, upd_set, upd_way, upd_inv, q_valid, q_set,
        input  victim_valid, victim_oh, victim_idx, upd_err
    );

    modport slave (
        input  upd_valid, upd_set, upd_way, upd_inv, q_valid, q_set,
        output victim_valid, victim_oh, victim_idx, upd_err
    );
endinterface

// File: rtl/lru_set_tracker.sv
// Per-set true-LRU age tracker with victim lookup and same-cycle update bypass.
// Latency: updates commit at the edge; query result registered one cycle later.
// Backpressure: none; updates and queries are accepted every cycle and never stall.
module lru_set_tracker #(
    parameter int WAYS = 4,
    parameter int SETS = 16
) (
    input  logic              clk,
    input  logic              rst,
    lru_set_tracker_if.slave  bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    typedef logic [WAY_W-1:0] age_t;
    localparam age_t AGE_LRU = age_t'(WAYS - 1);

    age_t             age_q [SETS][WAYS];

    logic [SET_W-1:0] upd_s;
    logic [SET_W-1:0] q_s;
    logic             way_onehot;
    logic             upd_ok;
    logic             bypass;
    age_t             hit_age;
    age_t             upd_age [WAYS];
    age_t             upd_new [WAYS];
    age_t             q_age   [WAYS];
    logic [WAYS-1:0]  q_oh;
    logic [WAY_W-1:0] q_idx;

    // A single-set configuration still carries a 1-bit set field; pin it to entry 0.
    assign upd_s = (SETS > 1) ? bus.upd_set : '0;
    assign q_s   = (SETS > 1) ? bus.q_set   : '0;

    assign way_onehot = (bus.upd_way != '0) &&
                        ((bus.upd_way & (bus.upd_way - WAYS'(1))) == '0);
    assign upd_ok     = bus.upd_valid && way_onehot;
    assign bypass     = upd_ok && (upd_s == q_s);

    always_comb begin
        hit_age = '0;
        for (int i = 0; i < WAYS; i++) begin
            upd_age[i] = age_q[upd_s][i];
        end
        for (int i = 0; i < WAYS; i++) begin
            if (bus.upd_way[i]) begin
                hit_age = hit_age | upd_age[i];
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            upd_new[i] = upd_age[i];
            if (bus.upd_inv) begin
                if (bus.upd_way[i]) begin
                    upd_new[i] = AGE_LRU;
                end else if (upd_age[i] > hit_age) begin
                    upd_new[i] = upd_age[i] - age_t'(1);
                end
            end else begin
                if (bus.upd_way[i]) begin
                    upd_new[i] = '0;
                end else if (upd_age[i] < hit_age) begin
                    upd_new[i] = upd_age[i] + age_t'(1);
                end
            end
        end
    end

    // Victim is the way holding the oldest age, seen after any same-set update this cycle.
    always_comb begin
        q_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            q_age[i] = bypass ? upd_new[i] : age_q[q_s][i];
            q_oh[i]  = (q_age[i] == AGE_LRU);
        end
        for (int i = 0; i < WAYS; i++) begin
            if (q_oh[i]) begin
                q_idx = q_idx | WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= age_t'(w);
                end
            end
            bus.victim_valid <= 1'b0;
            bus.victim_oh    <= '0;
            bus.victim_idx   <= '0;
            bus.upd_err      <= 1'b0;
        end else begin
            if (upd_ok) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[upd_s][w] <= upd_new[w];
                end
            end
            bus.upd_err      <= bus.upd_valid && !way_onehot;
            bus.victim_valid <= bus.q_valid;
            if (bus.q_valid) begin
                bus.victim_oh  <= q_oh;
                bus.victim_idx <= q_idx;
            end
        end
    end
endmodule

// File: tb/tb_lru_set_tracker.sv
// Directed bench for lru_set_tracker (WAYS=4, SETS=16) with hand-computed victims.
module tb_lru_set_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    lru_set_tracker_if #(.WAYS(4), .SETS(16)) bus ();

    lru_set_tracker #(.WAYS(4), .SETS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.upd_valid = 1'b0;
        bus.upd_set   = '0;
        bus.upd_way   = '0;
        bus.upd_inv   = 1'b0;
        bus.q_valid   = 1'b0;
        bus.q_set     = '0;
    endtask

    task automatic upd(input logic [3:0] set, input logic [3:0] way, input logic inv);
        bus.upd_valid = 1'b1;
        bus.upd_set   = set;
        bus.upd_way   = way;
        bus.upd_inv   = inv;
    endtask

    task automatic qry(input logic [3:0] set);
        bus.q_valid = 1'b1;
        bus.q_set   = set;
    endtask

    // One idle-update cycle with a query, then check the registered victim.
    task automatic query_chk(input string tag, input logic [3:0] set,
                             input logic [3:0] exp_oh, input logic [1:0] exp_idx);
        idle();
        qry(set);
        tick();
        idle();
        chk({tag, "_vld"}, 32'(bus.victim_valid), 32'd1);
        chk({tag, "_oh"},  32'(bus.victim_oh),    32'(exp_oh));
        chk({tag, "_idx"}, 32'(bus.victim_idx),   32'(exp_idx));
    endtask

    initial begin
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_vld", 32'(bus.victim_valid), 32'd0);
        chk("rst_oh",  32'(bus.victim_oh),    32'd0);
        chk("rst_idx", 32'(bus.victim_idx),   32'd0);
        chk("rst_err", 32'(bus.upd_err),      32'd0);

        query_chk("q_set0_reset", 4'd0, 4'b1000, 2'd3);
        tick();
        chk("hold_vld", 32'(bus.victim_valid), 32'd0);
        chk("hold_oh",  32'(bus.victim_oh),    32'h8);
        chk("hold_idx", 32'(bus.victim_idx),   32'd3);

        // Set 5: ages go [0,1,2,3] -> [1,2,3,0] -> [2,3,0,1] -> [3,0,1,2]
        upd(4'd5, 4'b1000, 1'b0); tick();
        upd(4'd5, 4'b0100, 1'b0); tick();
        upd(4'd5, 4'b0010, 1'b0); tick();
        query_chk("set5_lru", 4'd5, 4'b0001, 2'd0);
        query_chk("set6_untouched", 4'd6, 4'b1000, 2'd3);

        // Set 1: touching MRU way0 is a no-op; invalidating way2 gives [0,1,3,2]
        upd(4'd1, 4'b0001, 1'b0); tick();
        upd(4'd1, 4'b0100, 1'b1); tick();
        query_chk("set1_inv", 4'd1, 4'b0100, 2'd2);
        upd(4'd1, 4'b0100, 1'b0); tick();
        query_chk("set1_retouch", 4'd1, 4'b1000, 2'd3);

        // Same-cycle touch of set0 way3 and query of set0 sees [1,2,3,0]
        idle();
        upd(4'd0, 4'b1000, 1'b0);
        qry(4'd0);
        tick();
        idle();
        chk("bypass_oh",  32'(bus.victim_oh),  32'h4);
        chk("bypass_idx", 32'(bus.victim_idx), 32'd2);

        // Malformed update: flagged one cycle, no state change
        upd(4'd0, 4'b0110, 1'b0); tick();
        idle();
        chk("bad_err_set", 32'(bus.upd_err), 32'd1);
        query_chk("bad_unchanged", 4'd0, 4'b0100, 2'd2);
        chk("bad_err_clr", 32'(bus.upd_err), 32'd0);

        // All-zero way with a same-set query: no update, no bypass
        idle();
        upd(4'd0, 4'b0000, 1'b1);
        qry(4'd0);
        tick();
        idle();
        chk("zero_way_err", 32'(bus.upd_err),   32'd1);
        chk("zero_way_oh",  32'(bus.victim_oh), 32'h4);

        // Update set7 and query set5 concurrently: independent
        idle();
        upd(4'd7, 4'b1000, 1'b0);
        qry(4'd5);
        tick();
        idle();
        chk("indep_q5_oh", 32'(bus.victim_oh), 32'h1);
        chk("indep_err",   32'(bus.upd_err),   32'd0);
        query_chk("indep_set7", 4'd7, 4'b0100, 2'd2);

        // Invalidating the current LRU (way2) changes nothing, observed via bypass
        idle();
        upd(4'd7, 4'b0100, 1'b1);
        qry(4'd7);
        tick();
        idle();
        chk("inv_lru_oh", 32'(bus.victim_oh), 32'h4);

        // Invalidating MRU way3: [1,2,3,0] -> [0,1,2,3]
        idle();
        upd(4'd7, 4'b1000, 1'b1);
        qry(4'd7);
        tick();
        idle();
        chk("inv_mru_oh",  32'(bus.victim_oh),  32'h8);
        chk("inv_mru_idx", 32'(bus.victim_idx), 32'd3);

        // Reset wins over coincident malformed update, valid update and query
        idle();
        rst = 1'b1;
        upd(4'd0, 4'b0110, 1'b0);
        qry(4'd5);
        tick();
        upd(4'd0, 4'b1000, 1'b0);
        qry(4'd5);
        tick();
        rst = 1'b0;
        idle();
        chk("rst2_vld", 32'(bus.victim_valid), 32'd0);
        chk("rst2_oh",  32'(bus.victim_oh),    32'd0);
        chk("rst2_err", 32'(bus.upd_err),      32'd0);
        query_chk("rst2_set0", 4'd0, 4'b1000, 2'd3);
        chk("rst2_err_q", 32'(bus.upd_err), 32'd0);
        query_chk("rst2_set15", 4'd15, 4'b1000, 2'd3);
        query_chk("rst2_set5", 4'd5, 4'b1000, 2'd3);
        query_chk("rst2_set1", 4'd1, 4'b1000, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/lru_set_tracker.md
LRU_SET_TRACKER -- requirements
Module: lru_set_tracker

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WAYS, default 4, number of ways per set; legal values 2, 4, 8.
REQ-002 The block SHALL have parameter SETS, default 16, number of sets; legal values are powers of 2 from 1 to 64.
REQ-003 The block SHALL derive WAY_W = log2(WAYS) and SET_W = max(1, log2(SETS)).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 The block SHALL have port upd_valid, input, 1, update request this cycle.
REQ-007 The block SHALL have port upd_set, input, SET_W, set being updated.
REQ-008 The block SHALL have port upd_way, input, WAYS, one-hot way being updated.
REQ-009 The block SHALL have port upd_inv, input, 1, update type: 0 = touch (make MRU), 1 = invalidate (make LRU).
REQ-010 The block SHALL have port q_valid, input, 1, victim query request.
REQ-011 The block SHALL have port q_set, input, SET_W, set being queried.
REQ-012 The block SHALL have port victim_valid, output, 1, query result valid.
REQ-013 The block SHALL have port victim_oh, output, WAYS, one-hot LRU way of the queried set.
REQ-014 The block SHALL have port victim_idx, output, WAY_W, binary index of the same way.
REQ-015 The block SHALL have port upd_err, output, 1, malformed update flag.

Function
REQ-016 Each set SHALL hold one WAY_W-bit age per way; within a set, ages SHALL always be a permutation of 0..WAYS-1 (0 = MRU, WAYS-1 = LRU).
REQ-017 A touch of way w with age a SHALL set age(w)=0, increment every age < a in that set, and leave all other ages unchanged; touching the current MRU SHALL change nothing.
REQ-018 An invalidate of way w with age a SHALL set age(w)=WAYS-1, decrement every age > a in that set, and leave all other ages unchanged; invalidating the current LRU SHALL change nothing.
REQ-019 An update SHALL commit at the rising edge on which upd_valid=1, and SHALL modify only set upd_set.
REQ-020 If upd_valid=1 and upd_way is not exactly one-hot (zero or multiple bits set), the update SHALL be discarded with no state change, and upd_err SHALL be 1 in the following cycle only.
REQ-021 upd_err SHALL be 0 in every cycle not covered by REQ-020.
REQ-022 A query SHALL have latency 1: when q_valid=1 at edge N, then after edge N victim_valid=1, and victim_oh/victim_idx SHALL give the way of age WAYS-1 in set q_set.
REQ-023 If a valid, well-formed update targets q_set in the same cycle as the query, the result SHALL reflect the post-update ages (bypass).
REQ-024 When q_valid=0, victim_valid SHALL be 0 after the edge, and victim_oh/victim_idx SHALL hold their previous values.
REQ-025 Updates and queries to different sets in the same cycle SHALL be independent, and neither SHALL stall.
REQ-026 victim_oh SHALL always be one-hot whenever victim_valid=1.

Reset
REQ-027 When rst=1 at a rising edge, every set SHALL load age(way i)=i, so the LRU of every set is way WAYS-1.
REQ-028 When rst=1 at a rising edge, victim_valid, victim_oh, victim_idx and upd_err SHALL all be 0 after that edge.
REQ-029 rst SHALL take priority over any coincident update or query; these are discarded, including when rst is asserted mid-sequence.

Verification (WAYS=4, SETS=16)
REQ-030 Reset, then q_valid=1, q_set=0 -> next cycle victim_valid=1, victim_oh=4'b1000, victim_idx=3.
REQ-031 Set 5: touch way 3, then way 2, then way 1, then query -> victim_oh=4'b0001, victim_idx=0; other sets still report 4'b1000.
REQ-032 Set 1: touch way 0, then invalidate way 2, then query -> victim_oh=4'b0100; a subsequent touch of way 2 followed by a query -> victim_oh=4'b1000.
REQ-033 Set 0: same-cycle touch of way 3 plus query of set 0 -> next cycle victim_oh=4'b0100 (bypass).
REQ-034 Update with upd_way=4'b0110 -> upd_err=1 for exactly one cycle, and a following query returns the unchanged victim.
REQ-035 After several updates, assert rst together with upd_valid=1, then query sets 0 and 15 -> each returns victim_oh=4'b1000 and upd_err=0.
